// File: rtl/s3ga_cfg_pkg.sv
// s3ga_cfg_pkg: register map, bit indices and FSM state type for the S3GA config loader
package s3ga_cfg_pkg;
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_LEN    = 4'h8;
  localparam logic [3:0] OFF_DATA   = 4'hC;
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_FAB_RUN = 3;
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_OVF   = 4;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, LATCH, DONE} state_t;
endpackage

// File: rtl/s3ga_cfg_fifo.sv
// s3ga_cfg_fifo: synchronous FIFO; a push while full only lands when a pop frees the slot that cycle
module s3ga_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rptr[AW-1:0]];
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  // read/write pointers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
endmodule

// File: rtl/s3ga_cfg_loader.sv
// s3ga_cfg_loader: Wishbone config controller shifting bitstream frames into the S3GA chain
// Optional feature: S3GA_CFG_READBACK_EN captures cfg_di into a readback word returned on DATA reads.
module s3ga_cfg_loader
  import s3ga_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CFG_W      = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LEN_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  output logic [CFG_W-1:0] cfg_do,
  output logic             cfg_en,
  output logic             cfg_latch,
  input  logic [CFG_W-1:0] cfg_di,
  output logic             fab_rst_n,
  output logic             cfg_irq
);
  localparam int BEATS = 32 / CFG_W;
  state_t state, nxt;
  logic [LEN_W-1:0] len, remaining;
  logic [5:0] beat;
  logic [31:0] shreg, fifo_dout, rdata, rb_rd, bmask;
  logic [3:0] off;
  logic hit, wr, ctrl_wr, st_wr, len_wr, data_wr, stall, acc;
  logic start, abort, busy, pop, push, full, empty, last_beat;
  logic irq_en, fab_run, done, ovf;
  assign off = wbs_adr_i[3:0];
  assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr = hit & wbs_we_i;
  assign busy = state != IDLE;
  assign ctrl_wr = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign st_wr = wr & (off == OFF_STATUS);
  assign len_wr = wr & (off == OFF_LEN) & ~busy;
  assign data_wr = wr & (off == OFF_DATA) & (wbs_sel_i == 4'hF);
  assign abort = ctrl_wr & wbs_dat_i[CTRL_ABORT];
  assign start = ctrl_wr & wbs_dat_i[CTRL_START] & ~abort & ~busy;
  assign stall = data_wr & full & busy & ~pop;
  assign acc = hit & ~stall;
  assign push = data_wr & (~full | pop);
  assign last_beat = (state == SHIFT) && (beat == 6'(BEATS - 1));
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign cfg_do = shreg[CFG_W-1:0];
  assign cfg_irq = done & irq_en;

  s3ga_cfg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .push (push),
    .pop  (pop),
    .flush(abort),
    .din  (wbs_dat_i),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= nxt;

  // FSM next state; abort overrides everything
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = (len == '0) ? DONE : LOAD;
      LOAD:  nxt = empty ? WAIT : SHIFT;
      WAIT:  if (!empty) nxt = LOAD;
      SHIFT: if (last_beat) nxt = (remaining == LEN_W'(1)) ? LATCH : LOAD;
      LATCH: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // FSM outputs; abort kills chain activity in the same cycle
  always_comb begin
    cfg_en = (state == SHIFT) & ~abort;
    cfg_latch = (state == LATCH) & ~abort;
    pop = (state == LOAD) & ~empty & ~abort;
  end

  // shift datapath: word counter, beat counter, shift register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      remaining <= '0;
      beat <= '0;
      shreg <= '0;
    end else begin
      if (start) remaining <= len;
      else if (last_beat) remaining <= remaining - 1'b1;
      beat <= (state == SHIFT && !last_beat) ? beat + 1'b1 : '0;
      if (pop) shreg <= fifo_dout;
      else if (state == SHIFT) shreg <= shreg >> CFG_W;
    end

  // register file and Wishbone response
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en <= 1'b0;
      fab_run <= 1'b0;
      len <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      fab_rst_n <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
      if (ctrl_wr) begin
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        fab_run <= wbs_dat_i[CTRL_FAB_RUN];
      end
      if (len_wr) len <= (len & ~bmask[LEN_W-1:0]) | (wbs_dat_i[LEN_W-1:0] & bmask[LEN_W-1:0]);
      if (state == DONE) done <= 1'b1;
      else if (st_wr && wbs_dat_i[ST_DONE]) done <= 1'b0;
      if (data_wr && full && !busy) ovf <= 1'b1;
      else if (st_wr && wbs_dat_i[ST_OVF]) ovf <= 1'b0;
      fab_rst_n <= fab_run & ~busy;
    end

`ifdef S3GA_CFG_READBACK_EN
  logic [31:0] rb_sh, rb;
  logic [31+CFG_W:0] rb_cat;
  assign rb_cat = {cfg_di, rb_sh};
  assign rb_rd = rb;
  // chain tail enters at the top so the first beat ends in the LSB slice
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      rb_sh <= '0;
      rb <= '0;
    end else begin
      if (state == SHIFT) rb_sh <= rb_cat[31+CFG_W:CFG_W];
      if (last_beat) rb <= rb_cat[31+CFG_W:CFG_W];
    end
`else
  logic unused_di;
  assign unused_di = ^cfg_di;
  assign rb_rd = '0;
`endif

  // read mux
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata = {28'b0, fab_run, irq_en, 2'b0};
      OFF_STATUS: rdata = {27'b0, ovf, empty, full, done, busy};
      OFF_LEN:    rdata = 32'(len);
      OFF_DATA:   rdata = rb_rd;
      default:    rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_s3ga_cfg_loader.sv
// tb_s3ga_cfg_loader: directed self-checking bench for the S3GA config loader
module tb_s3ga_cfg_loader;
  localparam logic [31:0] B = 32'h3000_0000;
  logic clk = 0, rst_n = 0;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, dat_o;
  logic ack, cfg_en, cfg_latch, fab_rst_n, cfg_irq;
  logic [7:0] cfg_do, cfg_di;
  int vectors = 0, miscompares = 0;
  logic [7:0] beats[$];
  int latches = 0, cycle = 0, first_en = -1, latch_cyc = -1;
  logic [31:0] rd;
  int n;

  always #5 clk = ~clk;
  assign cfg_di = cfg_do;

  s3ga_cfg_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .cfg_do(cfg_do), .cfg_en(cfg_en), .cfg_latch(cfg_latch), .cfg_di(cfg_di),
    .fab_rst_n(fab_rst_n), .cfg_irq(cfg_irq)
  );

  // chain monitor sampled mid-cycle
  always @(negedge clk) begin
    cycle++;
    if (cfg_en) begin
      beats.push_back(cfg_do);
      if (first_en < 0) first_en = cycle;
    end
    if (cfg_latch) begin
      latches++;
      latch_cyc = cycle;
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int cnt);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!ack && cnt < 64);
    r = dat_o;
    cyc = 0; stb = 0; we = 0;
    if (!ack) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout adr=%h: no ack after %0d cycles, required ack", a, cnt);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int c;
    bus(1, B + a, d, 4'hF, r, c);
  endtask

  task automatic rdr(input logic [31:0] a, output logic [31:0] r);
    int c;
    bus(0, B + a, 0, 4'hF, r, c);
  endtask

  task automatic clear_mon();
    beats.delete();
    latches = 0; first_en = -1; latch_cyc = -1;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int i;
    s = 1;
    for (i = 0; i < 60 && s[0]; i++) rdr(32'h4, s);
    if (s[0]) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout status=%h, required busy=0", s);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cfg_en, cfg_latch, fab_rst_n, cfg_irq, ack, cfg_do, dat_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got en=%b latch=%b frst=%b irq=%b ack=%b do=%h dat=%h, required all 0",
               cfg_en, cfg_latch, fab_rst_n, cfg_irq, ack, cfg_do, dat_o);
    end
    @(negedge clk); rst_n = 1;
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h8) begin miscompares++; $display("FAIL reset_status got %h required 00000008", rd); end
    rdr(32'h8, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_len got %h required 0", rd); end
    rdr(32'h0, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl got %h required 0", rd); end
  endtask

  task automatic test_basic();
    logic [7:0] exp[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wr(32'h8, 2);
    wr(32'hC, 32'h44332211);
    wr(32'hC, 32'h88776655);
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL basic_status_loaded got %h required 0", rd); end
    clear_mon();
    wr(32'h0, 32'h1);
    wait_idle();
    vectors++;
    if (beats.size() != 8) begin miscompares++; $display("FAIL basic_beats got %0d required 8", beats.size()); end
    else for (int i = 0; i < 8; i++) begin
      vectors++;
      if (beats[i] !== exp[i]) begin miscompares++; $display("FAIL basic_do[%0d] got %h required %h", i, beats[i], exp[i]); end
    end
    vectors++;
    if (latches != 1) begin miscompares++; $display("FAIL basic_latch got %0d required 1", latches); end
    vectors++;
    if (latch_cyc - first_en != 9) begin miscompares++; $display("FAIL basic_timing got %0d required 9", latch_cyc - first_en); end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'hA) begin miscompares++; $display("FAIL basic_done got %h required 0000000a", rd); end
    wr(32'h0, 32'h8);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (fab_rst_n !== 1'b1) begin miscompares++; $display("FAIL basic_fab_rst got %b required 1", fab_rst_n); end
    wr(32'h4, 32'h2);
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h8) begin miscompares++; $display("FAIL basic_done_w1c got %h required 00000008", rd); end
  endtask

  task automatic test_wait();
    wr(32'h8, 3);
    wr(32'hC, 32'hA4A3A2A1);
    clear_mon();
    wr(32'h0, 32'h9);
    repeat (12) @(posedge clk); #1;
    vectors++;
    if (cfg_en !== 1'b0 || fab_rst_n !== 1'b0) begin
      miscompares++; $display("FAIL wait_idle_chain got en=%b frst=%b required 0 0", cfg_en, fab_rst_n);
    end
    vectors++;
    if (beats.size() != 4) begin miscompares++; $display("FAIL wait_beats1 got %0d required 4", beats.size()); end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h9) begin miscompares++; $display("FAIL wait_status got %h required 00000009", rd); end
    wr(32'hC, 32'hB4B3B2B1);
    wr(32'hC, 32'hC4C3C2C1);
    wait_idle();
    vectors++;
    if (beats.size() != 12 || beats[4] !== 8'hB1 || beats[11] !== 8'hC4) begin
      miscompares++;
      $display("FAIL wait_resume got n=%0d b4=%h b11=%h required 12 b1 c4", beats.size(), beats[4], beats[beats.size()-1]);
    end
    vectors++;
    if (latches != 1) begin miscompares++; $display("FAIL wait_latch got %0d required 1", latches); end
    vectors++;
    if (fab_rst_n !== 1'b1) begin miscompares++; $display("FAIL wait_fab_rst got %b required 1", fab_rst_n); end
    wr(32'h4, 32'h2);
  endtask

  task automatic test_ovf();
    for (int i = 0; i < 4; i++) wr(32'hC, 32'hA0A0A0A0 + i);
    bus(1, B + 32'hC, 32'h12345678, 4'hF, rd, n); vectors++;
    if (n != 1) begin miscompares++; $display("FAIL ovf_ack got %0d cycles required 1", n); end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h14) begin miscompares++; $display("FAIL ovf_status got %h required 00000014", rd); end
    wr(32'h4, 32'h10);
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL ovf_clear got %h required 00000004", rd); end
    wr(32'h8, 6);
    clear_mon();
    wr(32'h0, 32'h1);
    bus(1, B + 32'hC, 32'h0BADF00D, 4'hF, rd, n); vectors++;
    if (n != 1) begin miscompares++; $display("FAIL stall_fill got %0d cycles required 1", n); end
    bus(1, B + 32'hC, 32'hDEADBEEF, 4'hF, rd, n); vectors++;
    if (n != 3) begin miscompares++; $display("FAIL stall_wait got %0d cycles required 3", n); end
    wait_idle();
    vectors++;
    if (beats.size() != 24 || beats[20] !== 8'hEF || beats[23] !== 8'hDE) begin
      miscompares++; $display("FAIL stall_beats got n=%0d required 24 ending ef..de", beats.size());
    end
    vectors++;
    if (latches != 1) begin miscompares++; $display("FAIL stall_latch got %0d required 1", latches); end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'hA) begin miscompares++; $display("FAIL stall_status got %h required 0000000a", rd); end
    wr(32'h4, 32'h2);
  endtask

  task automatic test_abort();
    wr(32'h8, 2);
    wr(32'hC, 32'h44332211);
    wr(32'hC, 32'h88776655);
    clear_mon();
    wr(32'h0, 32'h1);
    @(posedge clk);
    wr(32'h0, 32'h2);
    vectors++;
    if (cfg_en !== 1'b0) begin miscompares++; $display("FAIL abort_en got %b required 0", cfg_en); end
    vectors++;
    if (beats.size() != 1 || beats[0] !== 8'h11) begin
      miscompares++; $display("FAIL abort_beats got n=%0d required 1 beat of 11", beats.size());
    end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h8) begin miscompares++; $display("FAIL abort_status got %h required 00000008", rd); end
    vectors++;
    if (latches != 0) begin miscompares++; $display("FAIL abort_latch got %0d required 0", latches); end
  endtask

  task automatic test_len0();
    logic [31:0] exp_rb;
`ifdef S3GA_CFG_READBACK_EN
    exp_rb = 32'hDEADBEEF;
`else
    exp_rb = 32'h0;
`endif
    wr(32'h0, 32'h4);
    wr(32'h8, 0);
    clear_mon();
    wr(32'h0, 32'h5);
    @(posedge clk); #1;
    vectors++;
    if (cfg_irq !== 1'b1) begin miscompares++; $display("FAIL len0_irq got %b required 1", cfg_irq); end
    vectors++;
    if (beats.size() != 0 || latches != 0) begin
      miscompares++; $display("FAIL len0_chain got beats=%0d latches=%0d required 0 0", beats.size(), latches);
    end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'hA) begin miscompares++; $display("FAIL len0_status got %h required 0000000a", rd); end
    wr(32'h4, 32'h2);
    vectors++;
    if (cfg_irq !== 1'b0) begin miscompares++; $display("FAIL len0_irq_clear got %b required 0", cfg_irq); end
    rdr(32'hC, rd); vectors++;
    if (rd !== exp_rb) begin miscompares++; $display("FAIL data_read got %h required %h", rd, exp_rb); end
  endtask

  task automatic test_sel();
    wr(32'h8, 32'hFFFF);
    bus(1, B + 32'h8, 32'h00001234, 4'h1, rd, n);
    rdr(32'h8, rd); vectors++;
    if (rd !== 32'hFF34) begin miscompares++; $display("FAIL sel_len got %h required 0000ff34", rd); end
    bus(1, B + 32'hC, 32'h55, 4'h3, rd, n); vectors++;
    if (n != 1) begin miscompares++; $display("FAIL sel_data_ack got %0d cycles required 1", n); end
    rdr(32'h4, rd); vectors++;
    if (rd !== 32'h8) begin miscompares++; $display("FAIL sel_data_drop got %h required 00000008", rd); end
    rdr(32'h2, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL undecoded got %h required 0", rd); end
    rdr(32'h0, rd); vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL ctrl_read got %h required 00000004", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_ovf();
    test_abort();
    test_len0();
    test_sel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
